// File: rtl/mux_scanner.sv
// mux_scanner: steps the select of an external 8:1 mux through channels 0..7,
// lets each channel settle for SETTLE cycles, samples the returned bit, and
// publishes the assembled byte once per scan.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request one scan (honoured only when idle)
//   cont   in   continuous mode, checked at the end of each scan
//   sel    out  [3:0] mux select, sel[3] is always 0
//   mux_o  in   bit returned by the mux for the current select
//   data   out  [7:0] last completed scan, data[k] = mux bit at sel = k
//   valid  out  one-cycle pulse when data updates
//   chg    out  one-cycle pulse alongside valid when data changed
//   busy   out  high whenever a scan is in progress (not idle)
module mux_scanner #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  output logic [3:0] sel,
  input  logic       mux_o,
  output logic [7:0] data,
  output logic       valid,
  output logic       chg,
  output logic       busy
);

  localparam int unsigned LP_CNT_W = 8;
  localparam logic [LP_CNT_W-1:0] LP_SETTLE = LP_CNT_W'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_k;
  logic [2:0]          w_k_nxt;
  logic [LP_CNT_W-1:0] r_cnt;
  logic [LP_CNT_W-1:0] w_cnt_nxt;
  logic [7:0]          r_shadow;
  logic [7:0]          w_shadow_nxt;
  logic [3:0]          r_sel;
  logic [3:0]          w_sel_nxt;
  logic [7:0]          r_data;
  logic [7:0]          w_data_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_chg;
  logic                w_chg_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic [7:0]          w_scan_word;
  logic [2:0]          w_k_inc;

  // Completed word: channel 7 is taken straight from the mux since its
  // shadow bit is only written on the same edge that publishes the result.
  assign w_scan_word = {mux_o, r_shadow[6:0]};
  assign w_k_inc     = r_k + 3'd1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_cnt == LP_CNT_W'(1)) w_state_nxt = S_SAMPLE;
      S_SAMPLE: w_state_nxt = (r_k == 3'd7) ? S_DONE : S_SETTLE;
      S_DONE:   w_state_nxt = cont ? S_SETTLE : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the datapath and output registers
  always_comb begin
    w_k_nxt      = r_k;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_sel_nxt    = r_sel;
    w_data_nxt   = r_data;
    w_valid_nxt  = 1'b0;
    w_chg_nxt    = 1'b0;
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_k_nxt   = 3'd0;
          w_cnt_nxt = LP_SETTLE;
          w_sel_nxt = 4'd0;
        end
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt - LP_CNT_W'(1);
      end
      S_SAMPLE: begin
        w_shadow_nxt[r_k] = mux_o;
        if (r_k != 3'd7) begin
          // Select only moves here, after the sample has been taken.
          w_k_nxt   = w_k_inc;
          w_cnt_nxt = LP_SETTLE;
          w_sel_nxt = {1'b0, w_k_inc};
        end else begin
          w_data_nxt  = w_scan_word;
          w_valid_nxt = 1'b1;
          w_chg_nxt   = (w_scan_word != r_data);
          w_sel_nxt   = 4'd0;
        end
      end
      S_DONE: begin
        if (cont) begin
          w_k_nxt   = 3'd0;
          w_cnt_nxt = LP_SETTLE;
          w_sel_nxt = 4'd0;
        end
      end
      default: begin
        w_sel_nxt = 4'd0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k      <= 3'd0;
      r_cnt    <= '0;
      r_shadow <= 8'd0;
      r_sel    <= 4'd0;
      r_data   <= 8'd0;
      r_valid  <= 1'b0;
      r_chg    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_k      <= w_k_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_sel    <= w_sel_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_chg    <= w_chg_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign sel   = r_sel;
  assign data  = r_data;
  assign valid = r_valid;
  assign chg   = r_chg;
  assign busy  = r_busy;

endmodule

// File: tb/tb_mux_scanner.sv
// Bench for mux_scanner: two instances (SETTLE=4 and SETTLE=1) each driven by
// a behavioural 8:1 mux. Expected select sequence, latency and result come from
// the scan timing arithmetic: channel k occupies cycles k*(S+1)+1..(k+1)*(S+1),
// result visible in cycle 8*(S+1)+1.
module tb_mux_scanner;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_start, a_cont, a_mux_o, a_valid, a_chg, a_busy;
  logic [3:0] a_sel;
  logic [7:0] a_data, a_pat;
  logic       b_rst, b_start, b_cont, b_mux_o, b_valid, b_chg, b_busy;
  logic [3:0] b_sel;
  logic [7:0] b_data, b_pat;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] prev_a = 8'd0;
  logic [7:0] prev_b = 8'd0;

  // Behavioural muxes
  assign a_mux_o = a_pat[a_sel[2:0]];
  assign b_mux_o = b_pat[b_sel[2:0]];

  mux_scanner #(.SETTLE(4)) u_dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .cont(a_cont), .sel(a_sel),
    .mux_o(a_mux_o), .data(a_data), .valid(a_valid), .chg(a_chg), .busy(a_busy)
  );

  mux_scanner #(.SETTLE(1)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .cont(b_cont), .sel(b_sel),
    .mux_o(b_mux_o), .data(b_data), .valid(b_valid), .chg(b_chg), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe(input bit w, output logic [3:0] s, output logic [7:0] d,
                         output logic v, output logic c, output logic b);
    if (w) begin s = b_sel; d = b_data; v = b_valid; c = b_chg; b = b_busy; end
    else   begin s = a_sel; d = a_data; v = a_valid; c = a_chg; b = a_busy; end
  endtask

  task automatic set_start(input bit w, input logic v);
    if (w) b_start = v; else a_start = v;
  endtask

  task automatic check_idle_outputs(input bit w, input string tag, input logic [7:0] exp_data);
    logic [3:0] s; logic [7:0] d; logic v, c, b;
    observe(w, s, d, v, c, b);
    check({tag, "_sel"},   {4'd0, s}, 8'd0);
    check({tag, "_busy"},  8'(b), 8'd0);
    check({tag, "_valid"}, 8'(v), 8'd0);
    check({tag, "_chg"},   8'(c), 8'd0);
    check({tag, "_data"},  d, exp_data);
  endtask

  // One scan, observed every cycle from cycle 1 to the result cycle.
  // Entry: either pulse start (use_start) or already at cycle 1 of a scan.
  task automatic scan(input bit w, input logic [7:0] pat, input bit use_start,
                      input bit spam, input bit drop_cont, input bit end_idle);
    int s_cyc;
    int lat;
    logic [7:0] prev;
    logic [3:0] so; logic [7:0] d; logic v, c, b;
    s_cyc = w ? 1 : 4;
    lat   = 8 * (s_cyc + 1) + 1;
    prev  = w ? prev_b : prev_a;
    if (w) b_pat = pat; else a_pat = pat;
    if (use_start) begin
      @(negedge clk); set_start(w, 1'b1);
      @(negedge clk); set_start(w, 1'b0);
    end
    for (int cy = 1; cy <= lat; cy++) begin
      observe(w, so, d, v, c, b);
      check("sel", {4'd0, so}, (cy < lat) ? 8'((cy - 1) / (s_cyc + 1)) : 8'd0);
      check("busy", 8'(b), 8'd1);
      check("valid", 8'(v), 8'(cy == lat));
      if (cy == lat) begin
        check("data", d, pat);
        check("chg", 8'(c), 8'(pat != prev));
      end else begin
        check("data_hold", d, prev);
      end
      if (spam) set_start(w, 1'($urandom_range(0, 1)));
      if (drop_cont && cy == 10) begin
        if (w) b_cont = 1'b0; else a_cont = 1'b0;
      end
      @(negedge clk);
    end
    set_start(w, 1'b0);
    if (w) prev_b = pat; else prev_a = pat;
    if (end_idle) begin
      for (int i = 0; i < 3; i++) begin
        check_idle_outputs(w, "post_idle", pat);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] pat;
    a_rst = 1'b1; a_start = 1'b0; a_cont = 1'b0; a_pat = 8'd0;
    b_rst = 1'b1; b_start = 1'b0; b_cont = 1'b0; b_pat = 8'd0;
    repeat (2) @(negedge clk);
    check_idle_outputs(1'b0, "rst_a", 8'd0);
    check_idle_outputs(1'b1, "rst_b", 8'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs(1'b0, "idle_a", 8'd0);

    // Basic scan, then an unchanged repeat
    scan(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    scan(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);

    // Continuous mode, pattern changes between scans; cont drops mid second scan
    a_cont = 1'b1;
    scan(1'b0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    scan(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b1);

    // start hammered while busy: single result, no queued scan
    scan(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset while sel = 5
    pat = 8'($urandom) | 8'h01;
    a_pat = pat;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    repeat (25) @(negedge clk);
    check("pre_rst_sel", {4'd0, a_sel}, 8'd5);
    #1 a_rst = 1'b1;
    #1 check_idle_outputs(1'b0, "async_rst", 8'd0);
    @(negedge clk); a_rst = 1'b0;
    prev_a = 8'd0;
    for (int i = 0; i < 4; i++) begin
      check_idle_outputs(1'b0, "after_rst", 8'd0);
      @(negedge clk);
    end
    scan(1'b0, pat, 1'b1, 1'b0, 1'b0, 1'b1);

    // SETTLE=1 instance, randomized patterns with occasional repeats
    for (int n = 0; n < 5; n++) begin
      pat = ($urandom_range(0, 2) == 0) ? prev_b : 8'($urandom);
      scan(1'b1, pat, 1'b1, 1'b0, 1'b0, 1'b1);
    end

    // A few more randomized scans on the SETTLE=4 instance
    for (int n = 0; n < 3; n++) begin
      pat = ($urandom_range(0, 2) == 0) ? prev_a : 8'($urandom);
      scan(1'b0, pat, 1'b1, 1'b0, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
